// File: rtl/uart_8250_rx.sv
// 8250-compatible UART receive path: 16x-oversampled deserialiser with parity, framing and break checks.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry receive queue; otherwise a single 16450-style holding register.
module uart_8250_rx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rxd,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    input  logic       rbr_rd,
    input  logic       lsr_rd,
    input  logic       fifo_clr,
    output logic [7:0] rx_data,
    output logic       dr,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       oe,
    output logic       rx_err,
    output logic [4:0] rx_level
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_WAIT   = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rxd_prev_r;
    logic                   rxd_s;
    logic                   fall_s;
    logic                   sample_s;
    logic [3:0]             tick_cnt_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             data_r;
    logic [1:0]             wls_r;
    logic                   pen_r;
    logic                   eps_r;
    logic                   sp_r;
    logic                   par_bit_r;
    logic                   pe_r;
    logic                   start_s;
    logic                   shift_s;
    logic                   par_smp_s;
    logic                   push_s;
    logic                   last_bit_s;
    logic                   par_exp_s;
    logic [10:0]            entry_s;
    logic [10:0]            head_s;
    logic                   pop_s;
    logic                   ovr_s;
    logic                   dr_s;
    logic                   err_s;
    logic                   oe_r;
    logic [4:0]             level_s;

    // Expected parity bit; stick parity forces the bit to the inverse of the even-select.
    function automatic logic parity_expected(input logic [7:0] d, input logic stick, input logic even);
        return stick ? ~even : (^d ^ ~even);
    endfunction

    // RXD synchroniser plus previous-value flop for start-edge detection; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r     <= {SYNC_STAGES{1'b1}};
            rxd_prev_r <= 1'b1;
        end else begin
            sync_r     <= {sync_r[SYNC_STAGES-2:0], rxd};
            rxd_prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rxd_s      = sync_r[SYNC_STAGES-1];
    assign fall_s     = rxd_prev_r & ~rxd_s;
    assign sample_s   = baud_tick & (tick_cnt_r == 4'd7);
    assign last_bit_s = (bit_cnt_r == (3'd4 + {1'b0, wls_r}));
    assign par_exp_s  = parity_expected(data_r, sp_r, eps_r);
    // Data above the word length is never written, so a zero compare covers all word lengths.
    assign entry_s    = {~rxd_s & ~par_bit_r & (data_r == 8'h00), ~rxd_s, pe_r, data_r};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and per-sample control strobes.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        shift_s     = 1'b0;
        par_smp_s   = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (sample_s) begin
                    state_nxt_s = rxd_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (sample_s) begin
                    shift_s = 1'b1;
                    if (last_bit_s) begin
                        state_nxt_s = pen_r ? ST_PARITY : ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (sample_s) begin
                    par_smp_s   = 1'b1;
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (sample_s) begin
                    push_s      = 1'b1;
                    state_nxt_s = rxd_s ? ST_IDLE : ST_WAIT;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_WAIT: begin
                if (rxd_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: tick counter, LCR snapshot, data capture and parity check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            data_r     <= 8'h00;
            wls_r      <= 2'd0;
            pen_r      <= 1'b0;
            eps_r      <= 1'b0;
            sp_r       <= 1'b0;
            par_bit_r  <= 1'b0;
            pe_r       <= 1'b0;
        end else if (start_s) begin
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            data_r     <= 8'h00;
            wls_r      <= wls;
            pen_r      <= pen;
            eps_r      <= eps;
            sp_r       <= sp;
            par_bit_r  <= 1'b0;
            pe_r       <= 1'b0;
        end else begin
            if (baud_tick) begin
                tick_cnt_r <= tick_cnt_r + 4'd1;
            end
            if (shift_s) begin
                data_r[bit_cnt_r] <= rxd_s;
                bit_cnt_r         <= bit_cnt_r + 3'd1;
            end
            if (par_smp_s) begin
                par_bit_r <= rxd_s;
                pe_r      <= rxd_s ^ par_exp_s;
            end
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [10:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [4:0]    level_r;
    logic [4:0]    err_cnt_r;
    logic          full_s;
    logic          wr_en_s;

    assign full_s  = (level_r == 5'(FIFO_DEPTH));
    assign dr_s    = (level_r != 5'd0);
    assign pop_s   = rbr_rd & dr_s;
    assign wr_en_s = push_s & (~full_s | pop_s);
    assign ovr_s   = push_s & full_s & ~pop_s;
    assign head_s  = mem_r[rd_ptr_r];
    assign err_s   = (err_cnt_r != 5'd0);
    assign level_s = level_r;

    // Circular queue; err_cnt_r tracks how many queued entries carry PE/FE/BI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 11'd0;
            end
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            level_r   <= 5'd0;
            err_cnt_r <= 5'd0;
        end else if (fifo_clr) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            level_r   <= 5'd0;
            err_cnt_r <= 5'd0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r   <= level_r + {4'd0, wr_en_s} - {4'd0, pop_s};
            err_cnt_r <= err_cnt_r + {4'd0, wr_en_s & (|entry_s[10:8])}
                                   - {4'd0, pop_s & (|head_s[10:8])};
        end
    end
`else
    logic [10:0] hold_r;
    logic        full_r;
    logic        unused_s;

    assign unused_s = fifo_clr ^ FIFO_DEPTH[0];
    assign dr_s     = full_r;
    assign pop_s    = rbr_rd & full_r;
    assign ovr_s    = push_s & full_r & ~pop_s;
    assign head_s   = hold_r;
    assign err_s    = full_r & (|hold_r[10:8]);
    assign level_s  = {4'd0, full_r};

    // Holding register: a new character always overwrites, overrun is flagged separately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r <= 11'd0;
            full_r <= 1'b0;
        end else if (push_s) begin
            hold_r <= entry_s;
            full_r <= 1'b1;
        end else if (pop_s) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end
`endif

    // Sticky overrun flag; a new overrun beats a coincident LSR read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oe_r <= 1'b0;
        end else if (ovr_s) begin
            oe_r <= 1'b1;
        end else if (lsr_rd) begin
            oe_r <= 1'b0;
        end else begin
            oe_r <= oe_r;
        end
    end

    assign rx_data  = head_s[7:0];
    assign pe       = head_s[8];
    assign fe       = head_s[9];
    assign bi       = head_s[10];
    assign dr       = dr_s;
    assign oe       = oe_r;
    assign rx_err   = err_s;
    assign rx_level = level_s;

endmodule
